// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_core
//  Brief    : UART transmitter. One bit period per clk cycle. Sends a start
//             bit, DATA_WIDTH data bits LSB first, an optional parity bit and
//             one stop bit. Frame configuration is captured at accept.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,        // asynchronous, active low
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  // Counter must hold DATA_WIDTH-1; keep at least one bit for tiny widths.
  localparam int             CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                state_q,  state_d;
  logic [CW-1:0]         cnt_q,    cnt_d;
  logic [DATA_WIDTH-1:0] data_q,   data_d;
  logic                  par_q,    par_d;
  logic                  par_en_q, par_en_d;
  logic                  tx_q,     tx_d;
  logic                  busy_q,   busy_d;

  // Next-state decode; frame contents are captured only on accept in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    case (state_q)
      S_IDLE: begin
        if (DATA_VALID) begin
          state_d  = S_START;
          data_d   = P_DATA;
          par_en_d = PAR_EN;
          par_d    = (^P_DATA) ^ PAR_TYP;
        end
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          state_d = par_en_q ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: state_d = S_STOP;
      S_STOP:   state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line and busy values for the state being entered, so they are registered
  // on the same edge as the state change.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    case (state_d)
      S_START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      S_DATA: begin
        tx_d   = data_q[cnt_d];
        busy_d = 1'b1;
      end
      S_PARITY: begin
        tx_d   = par_q;
        busy_d = 1'b1;
      end
      S_STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_core
//  Brief    : Directed self-checking bench for uart_tx_core.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_core;

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       busy;

  int total;
  int bad;

  uart_tx_core #(.DATA_WIDTH(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle request, then per-cycle check of the frame. Mid-frame the
  // inputs are scrambled and a stray request is pulsed while busy; neither
  // may alter this frame or start another one.
  task automatic send_frame(input string tag, input logic [7:0] d, input logic en,
                            input logic typ, input logic [15:0] exp, input int len);
    P_DATA     = d;
    PAR_EN     = en;
    PAR_TYP    = typ;
    DATA_VALID = 1'b1;
    @(negedge clk);
    DATA_VALID = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("%s_tx%0d", tag, i), {31'd0, TX_OUT}, {31'd0, exp[len-1-i]});
      check($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
      if (i == 2) begin
        P_DATA  = ~d;
        PAR_EN  = ~en;
        PAR_TYP = ~typ;
      end
      if (i == 4) DATA_VALID = 1'b1;
      if (i == 5) DATA_VALID = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("%s_idle_tx%0d", tag, k), {31'd0, TX_OUT}, 32'd1);
      check($sformatf("%s_idle_busy%0d", tag, k), {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    logic [15:0] exp_a;
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_tx", {31'd0, TX_OUT}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_tx", {31'd0, TX_OUT}, 32'd1);

    // A5 even parity: 0,1,0,1,0,0,1,0,1,0,1
    send_frame("a5_even", 8'hA5, 1'b1, 1'b0, 16'b010100101_01, 11);
    // A5 odd parity: 0,1,0,1,0,0,1,0,1,1,1
    send_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 16'b010100101_11, 11);
    // 3C no parity: 0,0,0,1,1,1,1,0,0,1
    send_frame("3c_nopar", 8'h3C, 1'b0, 1'b0, 16'b0001111001, 10);
    // 5A odd parity: data LSB first 0,1,0,1,1,0,1,0; four ones -> parity 1
    send_frame("5a_odd", 8'h5A, 1'b1, 1'b1, 16'b0_01011010_1_1, 11);

    // Held request: 01 then FF loaded mid-frame; FF follows after one idle.
    P_DATA     = 8'h01;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    DATA_VALID = 1'b1;
    exp_a      = 16'b0_10000000_1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold1_tx%0d", i), {31'd0, TX_OUT}, {31'd0, exp_a[9-i]});
      check($sformatf("hold1_busy%0d", i), {31'd0, busy}, 32'd1);
      if (i == 3) P_DATA = 8'hFF;
    end
    @(negedge clk);
    check("hold_gap_tx", {31'd0, TX_OUT}, 32'd1);
    check("hold_gap_busy", {31'd0, busy}, 32'd0);
    exp_a = 16'b0_11111111_1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) DATA_VALID = 1'b0;
      check($sformatf("hold2_tx%0d", i), {31'd0, TX_OUT}, {31'd0, exp_a[9-i]});
      check($sformatf("hold2_busy%0d", i), {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("hold_end_tx", {31'd0, TX_OUT}, 32'd1);
    check("hold_end_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset during data bit 4 (cycle 5 of the frame).
    P_DATA     = 8'h00;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    DATA_VALID = 1'b1;
    @(negedge clk);
    DATA_VALID = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_tx", {31'd0, TX_OUT}, 32'd0);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_tx", {31'd0, TX_OUT}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_idle_tx", {31'd0, TX_OUT}, 32'd1);
    check("rst_idle_busy", {31'd0, busy}, 32'd0);
    // 3C even parity after reset: four ones -> parity 0
    send_frame("post_rst", 8'h3C, 1'b1, 1'b0, 16'b0_00111100_0_1, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
